// File: rtl/ibex_regfile_write_sched_if.sv
// Request bundle between the writeback stage / auxiliary requester and the
// register file write-port scheduler.
interface ibex_regfile_write_sched_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 wb_we;
  logic [4:0]           wb_waddr;
  logic [DataWidth-1:0] wb_wdata;
  logic                 wb_stall;

  logic                 aux_req;
  logic [4:0]           aux_waddr;
  logic [DataWidth-1:0] aux_wdata;
  logic                 aux_gnt;

  modport master (
    output wb_we, wb_waddr, wb_wdata, aux_req, aux_waddr, aux_wdata,
    input  wb_stall, aux_gnt
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, aux_req, aux_waddr, aux_wdata,
    output wb_stall, aux_gnt
  );
endinterface

// File: rtl/ibex_regfile_write_sched.sv
// Shares the single register file write port between writeback and an auxiliary
// requester. The post-reset clearing sweep is built only with IBEX_RF_SCHED_INIT_EN.
module ibex_regfile_write_sched #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          MaxStarve   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  ibex_regfile_write_sched_if.slave  req,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_waddr_o,
  output logic [DataWidth-1:0]       rf_wdata_o,
  output logic                       init_busy_o,
  output logic                       err_o
);

  localparam int unsigned NumWords  = RV32E ? 16 : 32;
  localparam logic [3:0]  StarveMax = 4'(MaxStarve);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e               state;
  logic [3:0]           starve;
  logic [3:0]           starve_d;
  logic                 in_init;
  logic                 stall;
  logic                 aux_gnt;
  logic                 sel_valid;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;

`ifdef IBEX_RF_SCHED_INIT_EN
  localparam logic [4:0] LastPtr = 5'(NumWords - 1);
  logic [4:0] ptr;
`else
  assign state = RUN;
`endif

  assign in_init      = (state == INIT);
  assign stall        = in_init || (starve == StarveMax);
  assign req.wb_stall = stall;
  assign req.aux_gnt  = aux_gnt;
  assign err_o        = stall && req.wb_we;
  assign init_busy_o  = in_init;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    aux_gnt   = 1'b0;
    sel_valid = 1'b0;
    sel_addr  = req.wb_waddr;
    sel_data  = req.wb_wdata;
`ifdef IBEX_RF_SCHED_INIT_EN
    if (in_init) begin
      sel_valid = 1'b1;
      sel_addr  = ptr;
      sel_data  = WordZeroVal;
    end else
`endif
    if (req.wb_we) begin
      sel_valid = 1'b1;
    end else if (req.aux_req) begin
      aux_gnt   = 1'b1;
      sel_valid = 1'b1;
      sel_addr  = req.aux_waddr;
      sel_data  = req.aux_wdata;
    end
    // The 16-entry file has no x16..x31; fold the address onto the live range.
    if (RV32E) sel_addr[4] = 1'b0;
  end

  assign rf_we_o    = sel_valid && (sel_addr != 5'd0);
  assign rf_waddr_o = sel_addr;
  assign rf_wdata_o = sel_data;

  // A protocol-violating writeback during a stall still owns the port, so the
  // starvation count must not be lost on that cycle.
  always_comb begin
    starve_d = starve;
    if (!in_init && !err_o) begin
      if (aux_gnt || !req.aux_req) begin
        starve_d = '0;
      end else if (starve != StarveMax) begin
        starve_d = starve + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve <= '0;
`ifdef IBEX_RF_SCHED_INIT_EN
      state  <= INIT;
      ptr    <= 5'd1;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      starve <= starve_d;
`ifdef IBEX_RF_SCHED_INIT_EN
      if (state == INIT) begin
        ptr <= ptr + 5'd1;
        if (ptr == LastPtr) state <= RUN;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ibex_regfile_write_sched.sv
// Randomized self-checking bench for ibex_regfile_write_sched: a 32-entry and a
// 16-entry instance share stimulus and are checked against a cycle-level model.
`timescale 1ns/1ps
module tb_ibex_regfile_write_sched;

  localparam int unsigned DW       = 32;
  localparam logic [31:0] WordZero = 32'hDEAD_BEEF;
`ifdef IBEX_RF_SCHED_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        err;
  } outs_t;

  logic        clk_i;
  logic        rst_ni;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        aux_req;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata;

  logic        rf_we_a, busy_a, err_a, rf_we_b, busy_b, err_b;
  logic [4:0]  rf_waddr_a, rf_waddr_b;
  logic [31:0] rf_wdata_a, rf_wdata_b;

  int checks = 0;
  int errors = 0;
  int since_rst [2];
  int streak [2];

  ibex_regfile_write_sched_if #(.DataWidth(DW)) bus_a ();
  ibex_regfile_write_sched_if #(.DataWidth(DW)) bus_b ();

  assign bus_a.wb_we = wb_we;     assign bus_b.wb_we = wb_we;
  assign bus_a.wb_waddr = wb_waddr; assign bus_b.wb_waddr = wb_waddr;
  assign bus_a.wb_wdata = wb_wdata; assign bus_b.wb_wdata = wb_wdata;
  assign bus_a.aux_req = aux_req;   assign bus_b.aux_req = aux_req;
  assign bus_a.aux_waddr = aux_waddr; assign bus_b.aux_waddr = aux_waddr;
  assign bus_a.aux_wdata = aux_wdata; assign bus_b.aux_wdata = aux_wdata;

  ibex_regfile_write_sched #(
    .RV32E(1'b0), .DataWidth(DW), .WordZeroVal(WordZero), .MaxStarve(4)
  ) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .req(bus_a),
    .rf_we_o(rf_we_a), .rf_waddr_o(rf_waddr_a), .rf_wdata_o(rf_wdata_a),
    .init_busy_o(busy_a), .err_o(err_a)
  );

  ibex_regfile_write_sched #(
    .RV32E(1'b1), .DataWidth(DW), .WordZeroVal(WordZero), .MaxStarve(2)
  ) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .req(bus_b),
    .rf_we_o(rf_we_b), .rf_waddr_o(rf_waddr_b), .rf_wdata_o(rf_wdata_b),
    .init_busy_o(busy_b), .err_o(err_b)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int max_s(int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int num_words(int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic bit model_init(int d);
    return InitEn && (since_rst[d] < num_words(d) - 1);
  endfunction

  function automatic outs_t canon(outs_t o);
    outs_t c = o;
    if (!c.we) begin
      c.waddr = '0;
      c.wdata = '0;
    end
    return c;
  endfunction

  function automatic outs_t model_out(int d);
    outs_t      o;
    logic [4:0] a;
    o = '0;
    a = '0;
    if (model_init(d)) begin
      o.stall = 1'b1;
      o.busy  = 1'b1;
      o.we    = 1'b1;
      a       = 5'(since_rst[d] + 1);
      o.wdata = WordZero;
    end else begin
      o.stall = (streak[d] >= max_s(d));
      if (wb_we) begin
        o.we = 1'b1; a = wb_waddr; o.wdata = wb_wdata;
      end else if (aux_req) begin
        o.we = 1'b1; o.gnt = 1'b1; a = aux_waddr; o.wdata = aux_wdata;
      end
    end
    if (d == 1) a = a % 16;
    o.waddr = a;
    if (a == 5'd0) o.we = 1'b0;
    o.err = o.stall && wb_we;
    return canon(o);
  endfunction

  function automatic outs_t observe(int d);
    outs_t o;
    if (d == 0) begin
      o.stall = bus_a.wb_stall; o.gnt = bus_a.aux_gnt; o.we = rf_we_a;
      o.waddr = rf_waddr_a; o.wdata = rf_wdata_a; o.busy = busy_a; o.err = err_a;
    end else begin
      o.stall = bus_b.wb_stall; o.gnt = bus_b.aux_gnt; o.we = rf_we_b;
      o.waddr = rf_waddr_b; o.wdata = rf_wdata_b; o.busy = busy_b; o.err = err_b;
    end
    return canon(o);
  endfunction

  function automatic void model_step(int d);
    outs_t o;
    o = model_out(d);
    if (!model_init(d) && !o.err) begin
      if (o.gnt || !aux_req) streak[d] = 0;
      else if (streak[d] < max_s(d)) streak[d] = streak[d] + 1;
    end
    if (since_rst[d] < 1000) since_rst[d] = since_rst[d] + 1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      since_rst[d] = 0;
      streak[d]    = 0;
    end
  endfunction

  task automatic advance();
    @(posedge clk_i);
    if (rst_ni) begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
    #1;
  endtask

  task automatic set_inputs(logic we, logic [4:0] wa, logic [31:0] wd,
                            logic rq, logic [4:0] aa, logic [31:0] ad);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    aux_req = rq; aux_waddr = aa; aux_wdata = ad;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    outs_t e, g;
    rst_ni = 1'b0;
    model_reset();
    set_inputs(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      e = model_out(d); g = observe(d); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset dut%0d: got %h want %h", d, g, e);
      end
    end
    advance();
    rst_ni = 1'b1;
  endtask

  task automatic test_init_sweep();
    outs_t e, g;
    for (int i = 0; i < 34; i++) begin
      set_inputs(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        e = model_out(d); g = observe(d); checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL sweep dut%0d cyc%0d: got %h want %h", d, i, g, e);
        end
      end
      advance();
    end
  endtask

  task automatic test_starvation();
    outs_t e, g;
    int    denied = 0;
    bit    granted = 1'b0;
    set_inputs(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    advance();
    for (int i = 0; i < 12 && !granted; i++) begin
      // Well-behaved core: withdraws its write whenever the stall is up.
      set_inputs(!model_out(0).stall, 5'($urandom_range(1, 31)), $urandom,
                 1'b1, 5'h07, 32'hA5A5_0007);
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        e = model_out(d); g = observe(d); checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL starve dut%0d cyc%0d: got %h want %h", d, i, g, e);
        end
      end
      if (bus_a.aux_gnt === 1'b1) granted = 1'b1;
      else denied++;
      advance();
    end
    checks++;
    if (!granted || denied != 4) begin
      errors++;
      $display("FAIL starve_bound: got %0d denied (granted=%0d) want 4 denied then grant",
               denied, granted);
    end
  endtask

  task automatic test_back_to_back_err();
    outs_t e, g;
    set_inputs(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    advance();
    for (int i = 0; i < 7; i++) begin
      set_inputs(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'h09, 32'h0000_0909);
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        e = model_out(d); g = observe(d); checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL err dut%0d cyc%0d: got %h want %h", d, i, g, e);
        end
      end
      if (i == 4) begin
        checks++;
        if (err_a !== 1'b1 || bus_a.aux_gnt !== 1'b0 || rf_waddr_a !== wb_waddr) begin
          errors++;
          $display("FAIL err_stall: got err=%b gnt=%b addr=%h want err=1 gnt=0 addr=%h",
                   err_a, bus_a.aux_gnt, rf_waddr_a, wb_waddr);
        end
      end
      advance();
    end
  endtask

  task automatic test_aux_x0_and_mask();
    outs_t e, g;
    set_inputs(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h0000_1234);
    @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      e = model_out(d); g = observe(d); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL aux_x0 dut%0d: got %h want %h", d, g, e);
      end
    end
    checks++;
    if (bus_a.aux_gnt !== 1'b1 || rf_we_a !== 1'b0) begin
      errors++;
      $display("FAIL aux_x0_direct: got gnt=%b we=%b want gnt=1 we=0", bus_a.aux_gnt, rf_we_a);
    end
    advance();
    set_inputs(1'b0, 5'd0, '0, 1'b1, 5'h13, 32'h0BAD_F00D);
    @(negedge clk_i);
    checks++;
    if (bus_b.aux_gnt !== 1'b1 || rf_waddr_b !== 5'h03 || rf_we_b !== 1'b1) begin
      errors++;
      $display("FAIL rv32e_mask: got gnt=%b addr=%h we=%b want gnt=1 addr=03 we=1",
               bus_b.aux_gnt, rf_waddr_b, rf_we_b);
    end
    checks++;
    if (rf_waddr_a !== 5'h13) begin
      errors++;
      $display("FAIL rv32i_addr: got %h want 13", rf_waddr_a);
    end
    advance();
  endtask

  task automatic test_random();
    outs_t e, g;
    for (int i = 0; i < 400; i++) begin
      set_inputs(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
                 1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom);
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        e = model_out(d); g = observe(d); checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", d, i, g, e);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_sweep();
    outs_t e, g;
    rst_ni = 1'b0;
    model_reset();
    set_inputs(1'b0, 5'd0, '0, 1'b1, 5'h05, 32'h5555_0005);
    advance();
    rst_ni = 1'b1;
    while (since_rst[0] < 9) advance();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        rst_ni = 1'b0;
        model_reset();
        #1;
      end
      if (k == 2) rst_ni = 1'b1;
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        e = model_out(d); g = observe(d); checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL midreset dut%0d step%0d: got %h want %h", d, k, g, e);
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_starvation();
    test_back_to_back_err();
    test_aux_x0_and_mask();
    test_random();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
